// File: rtl/fft_pkg.sv
// Shared constants, field types and sequencer states for the radix-2 DIT FFT control path.
package fft_pkg;
    localparam int N_POINTS        = 64;
    localparam int LOG2N           = 6;
    localparam int MAX_OUTSTANDING = 4;
    localparam int STAGE_W         = $clog2(LOG2N);

    typedef logic [LOG2N-1:0]   idx_t;
    typedef logic [LOG2N-2:0]   tw_idx_t;
    typedef logic [STAGE_W-1:0] stage_t;
    typedef logic [LOG2N-2:0]   bf_cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;
endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly address generator: (stage, k) -> operand pair, twiddle index, last-of-stage flag.
// Purely combinational, zero latency; no flow control (the caller registers the outputs).
module fft_bf_addr_gen #(
    parameter int N_POINTS = fft_pkg::N_POINTS,
    parameter int LOG2N    = fft_pkg::LOG2N,
    parameter int STAGE_W  = fft_pkg::STAGE_W
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [LOG2N-2:0]   k,
    output logic [LOG2N-1:0]   idx_a,
    output logic [LOG2N-1:0]   idx_b,
    output logic [LOG2N-2:0]   tw_idx,
    output logic               last
);
    localparam logic [LOG2N-1:0]   ONE      = 1;
    localparam logic [LOG2N-2:0]   LAST_K   = (LOG2N-1)'(N_POINTS/2 - 1);
    localparam logic [STAGE_W-1:0] TW_SHIFT = (STAGE_W)'(LOG2N - 1);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] group;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] tw_full;

    always_comb begin
        k_ext   = {1'b0, k};
        half    = ONE << stage;
        group   = k_ext >> stage;
        pos     = k_ext & (half - ONE);
        // Insert a zero at bit 'stage' of k: top operand of the pair, partner is +half.
        idx_a   = ((group << stage) << 1) | pos;
        idx_b   = idx_a + half;
        tw_full = pos << (TW_SHIFT - stage);
        tw_idx  = tw_full[LOG2N-2:0];
        last    = (k == LAST_K);
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT; command fields registered (1 cycle).
// Backpressure: bf_valid holds commands stable until bf_ready; issue stalls at MAX_OUTSTANDING in flight.
module fft_stage_sequencer #(
    parameter int N_POINTS        = fft_pkg::N_POINTS,
    parameter int LOG2N           = fft_pkg::LOG2N,
    parameter int MAX_OUTSTANDING = fft_pkg::MAX_OUTSTANDING
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     stage_done,
    output logic                     bf_valid,
    input  logic                     bf_ready,
    output logic [LOG2N-1:0]         bf_idx_a,
    output logic [LOG2N-1:0]         bf_idx_b,
    output logic [LOG2N-2:0]         bf_tw_idx,
    output logic [$clog2(LOG2N)-1:0] bf_stage,
    output logic                     bf_last,
    input  logic                     wb_valid,
    output logic                     err_wb
);
    import fft_pkg::*;

    localparam int                 SW         = $clog2(LOG2N);
    localparam int                 OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]   MAX_OUT    = (OUT_W)'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]   ONE_O      = 1;
    localparam logic [LOG2N-2:0]   ONE_K      = 1;
    localparam logic [SW-1:0]      ONE_S      = 1;
    localparam logic [SW-1:0]      LAST_STAGE = (SW)'(LOG2N - 1);

    seq_state_t       state, state_nxt;
    logic [SW-1:0]    stage, stage_nxt;
    logic [LOG2N-2:0] k, k_nxt;
    logic [OUT_W-1:0] outstanding, out_nxt;
    logic             xfer;
    logic             start_ok;
    logic             wb_err;

    logic [LOG2N-1:0] g_idx_a;
    logic [LOG2N-1:0] g_idx_b;
    logic [LOG2N-2:0] g_tw_idx;
    logic             g_last;

    // Addresses are generated for the next (stage, k) so the registered fields line up with the counters.
    fft_bf_addr_gen #(
        .N_POINTS (N_POINTS),
        .LOG2N    (LOG2N),
        .STAGE_W  (SW)
    ) u_addr_gen (
        .stage  (stage_nxt),
        .k      (k_nxt),
        .idx_a  (g_idx_a),
        .idx_b  (g_idx_b),
        .tw_idx (g_tw_idx),
        .last   (g_last)
    );

    always_comb begin
        xfer      = bf_valid & bf_ready;
        start_ok  = start && (state == IDLE);
        state_nxt = state;
        stage_nxt = stage;
        k_nxt     = k;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    stage_nxt = '0;
                    k_nxt     = '0;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    if (bf_last) state_nxt = DRAIN;
                    else         k_nxt     = k + ONE_K;
                end
            end
            DRAIN: begin
                if (outstanding == '0) begin
                    if (stage == LAST_STAGE) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        stage_nxt = stage + ONE_S;
                        k_nxt     = '0;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // A writeback paired with a transfer in the same cycle leaves the count untouched.
        out_nxt = outstanding;
        wb_err  = wb_valid && (outstanding == '0);
        if (xfer && !wb_valid)
            out_nxt = outstanding + ONE_O;
        else if (!xfer && wb_valid && (outstanding != '0))
            out_nxt = outstanding - ONE_O;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            stage       <= '0;
            k           <= '0;
            outstanding <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stage_done  <= 1'b0;
            bf_valid    <= 1'b0;
            bf_idx_a    <= '0;
            bf_idx_b    <= '0;
            bf_tw_idx   <= '0;
            bf_stage    <= '0;
            bf_last     <= 1'b0;
            err_wb      <= 1'b0;
        end else begin
            state       <= state_nxt;
            stage       <= stage_nxt;
            k           <= k_nxt;
            outstanding <= out_nxt;
            busy        <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            done        <= (state_nxt == DONE);
            stage_done  <= (state == DRAIN) && (outstanding == '0);
            bf_valid    <= (state_nxt == ISSUE) && (out_nxt < MAX_OUT);
            if (state_nxt == ISSUE) begin
                bf_idx_a  <= g_idx_a;
                bf_idx_b  <= g_idx_b;
                bf_tw_idx <= g_tw_idx;
                bf_stage  <= stage_nxt;
                bf_last   <= g_last;
            end else begin
                bf_last   <= 1'b0;
            end
            if (start_ok) err_wb <= 1'b0;
            if (wb_err)   err_wb <= 1'b1;
        end
    end
endmodule
